// File: rtl/mpemu_core.sv
// -----------------------------------------------------------------------------
// mpemu_core
//   Pipelined signed multiplier emulation for the dmix mixer datapath.
//   Multiplies a signed 24-bit sample by a signed 16-bit coefficient and
//   returns the exact signed 40-bit product LATENCY rising edges after capture
//   (the capture edge counts as the first). Throughput is one pair per cycle.
//
//   Optional build macro: MPEMU_ROUNDSAT_EN
//     When defined, adds mprod24_o: product >>> 15, rounded half-up on bit 14
//     and saturated to 24 bits, time-aligned with mprod_o.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   synchronous active-low reset, clears every stage
//   mpcand_i   in   24  signed multiplicand
//   mplier_i   in   16  signed multiplier
//   mprod_o    out  40  signed product, registered
//   mprod24_o  out  24  rounded/saturated Q-shifted product (macro only)
// -----------------------------------------------------------------------------
module mpemu_core #(
    parameter int LATENCY = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] mpcand_i,
    input  logic [15:0] mplier_i,
    output logic [39:0] mprod_o
`ifdef MPEMU_ROUNDSAT_EN
    ,
    output logic [23:0] mprod24_o
`endif
);

    // Product shift register depth. With LATENCY==1 the operand register is
    // skipped and the product register itself is the only stage.
    localparam int STG = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic signed [39:0] mul;
    logic signed [39:0] pipe [STG];

    generate
        if (LATENCY == 1) begin : g_comb
            always_comb begin
                mul = $signed({{16{mpcand_i[23]}}, mpcand_i})
                    * $signed({{24{mplier_i[15]}}, mplier_i});
            end
        end else begin : g_opreg
            logic [23:0] cand_q;
            logic [15:0] plier_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cand_q  <= '0;
                    plier_q <= '0;
                end else begin
                    cand_q  <= mpcand_i;
                    plier_q <= mplier_i;
                end
            end

            // 40x40 signed multiply truncated to 40 bits is exact here
            // because 24+16 bits cannot overflow a 40-bit result.
            always_comb begin
                mul = $signed({{16{cand_q[23]}}, cand_q})
                    * $signed({{24{plier_q[15]}}, plier_q});
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STG; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mul;
            for (int i = 1; i < STG; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign mprod_o = pipe[STG-1];

`ifdef MPEMU_ROUNDSAT_EN
    function automatic logic [23:0] round_sat(input logic signed [39:0] p);
        logic signed [39:0] sh;
        logic signed [39:0] t;
        // Shift held in its own signed variable so the add below cannot turn
        // the arithmetic shift into a logical one.
        sh = p >>> 15;
        t  = sh + $signed({39'd0, p[14]});
        if (t > 40'sd8388607)       return 24'h7FFFFF;
        else if (t < -40'sd8388608) return 24'h800000;
        else                        return t[23:0];
    endfunction

    // Value entering the final product register; rounding is registered in
    // parallel with it so mprod24_o tracks mprod_o cycle for cycle.
    logic signed [39:0] last_d;
    logic [23:0]        rs_q;

    generate
        if (STG == 1) begin : g_last_mul
            assign last_d = mul;
        end else begin : g_last_pipe
            assign last_d = pipe[STG-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) rs_q <= '0;
        else        rs_q <= round_sat(last_d);
    end

    assign mprod24_o = rs_q;
`endif

endmodule

// File: tb/tb_mpemu_core.sv
// -----------------------------------------------------------------------------
// tb_mpemu_core
//   Three instances (LATENCY 6, 1, 8) share one stimulus stream. The reference
//   model records every edge's inputs and reset, and derives each instance's
//   expected output from that history with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mpemu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] mpcand;
    logic [15:0] mplier;
    logic [39:0] p6, p1, p8;
`ifdef MPEMU_ROUNDSAT_EN
    logic [23:0] q6, q1, q8;
`endif

    always #5 clk = ~clk;

    mpemu_core #(.LATENCY(6)) u6 (.clk(clk), .rst_n(rst_n), .mpcand_i(mpcand),
        .mplier_i(mplier), .mprod_o(p6)
`ifdef MPEMU_ROUNDSAT_EN
        , .mprod24_o(q6)
`endif
    );
    mpemu_core #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .mpcand_i(mpcand),
        .mplier_i(mplier), .mprod_o(p1)
`ifdef MPEMU_ROUNDSAT_EN
        , .mprod24_o(q1)
`endif
    );
    mpemu_core #(.LATENCY(8)) u8 (.clk(clk), .rst_n(rst_n), .mpcand_i(mpcand),
        .mplier_i(mplier), .mprod_o(p8)
`ifdef MPEMU_ROUNDSAT_EN
        , .mprod24_o(q8)
`endif
    );

    // Edge-indexed history seen by the model.
    localparam int HMAX = 4096;
    longint hist_a [HMAX];
    longint hist_b [HMAX];
    bit     hist_r [HMAX];
    int     edge_n = 0;
    int     vecs   = 0;
    int     errs   = 0;

    // Output after edge k for a pipe of depth L: product of the pair captured
    // at edge k-L+1, unless a reset edge falls in that window.
    function automatic longint exp_prod(int lat, int k);
        int c;
        c = k - lat + 1;
        if (c < 0) return 0;
        for (int j = c; j <= k; j++) if (hist_r[j]) return 0;
        return hist_a[c] * hist_b[c];
    endfunction

    // Round half-up of p / 2^15, then clamp to the 24-bit signed range.
    function automatic longint exp_rs(longint p);
        longint t;
        t = (p + 64'sd16384) >>> 15;
        if (t > 8388607)  t = 8388607;
        if (t < -8388608) t = -8388608;
        return t;
    endfunction

    task automatic chk(input string tag, input int lat, input logic [39:0] got,
                       input logic [23:0] got24);
        longint     e;
        logic [39:0] e40;
        logic [23:0] e24;
        e   = exp_prod(lat, edge_n);
        e40 = e[39:0];
        vecs++;
        assert (got === e40) else begin
            errs++;
            $error("FAIL %s L=%0d edge=%0d mprod got=%0d exp=%0d", tag, lat, edge_n,
                   $signed(got), e);
        end
`ifdef MPEMU_ROUNDSAT_EN
        e   = exp_rs(e);
        e24 = e[23:0];
        vecs++;
        assert (got24 === e24) else begin
            errs++;
            $error("FAIL %s24 L=%0d edge=%0d mprod24 got=%0d exp=%0d", tag, lat, edge_n,
                   $signed(got24), $signed(e24));
        end
`else
        e24 = got24;
`endif
    endtask

    // Drive one edge's inputs, let the edge happen, record it, then check.
    task automatic step(input longint a, input longint b, input bit rst);
        logic [23:0] a24;
        logic [15:0] b16;
        a24    = a[23:0];
        b16    = b[15:0];
        mpcand = a24;
        mplier = b16;
        rst_n  = ~rst;
        @(posedge clk);
        hist_a[edge_n] = longint'($signed(a24));
        hist_b[edge_n] = longint'($signed(b16));
        hist_r[edge_n] = rst;
        #1;
`ifdef MPEMU_ROUNDSAT_EN
        chk("p6", 6, p6, q6);
        chk("p1", 1, p1, q1);
        chk("p8", 8, p8, q8);
`else
        chk("p6", 6, p6, 24'd0);
        chk("p1", 1, p1, 24'd0);
        chk("p8", 8, p8, 24'd0);
`endif
        edge_n++;
    endtask

    initial begin
        logic [23:0] ra;
        logic [15:0] rb;
        rst_n  = 1'b0;
        mpcand = '0;
        mplier = '0;

        // Reset, then the directed sample/coefficient sequence.
        step(0, 0, 1);
        step(0, 0, 1);
        step(64'sh10000, 0, 0);
        step(64'sh10000, 2, 0);
        step(64'sh30000, 4, 0);
        step(64'sh50000, 6, 0);
        step(-64'sh10000, 20, 0);
        step(-64'sh20000, -30, 0);
        repeat (10) step(0, 0, 0);

        // Single-cycle pulse for latency placement.
        step(3, 5, 0);
        repeat (10) step(0, 0, 0);

        // Full-range corners.
        step(-8388608, -32768, 0);
        step(8388607, -32768, 0);
        step(-1, -1, 0);
        step(8388607, 32767, 0);
        step(-8388608, 32767, 0);
        // Rounding/saturation points.
        step(64'sh10000, 16384, 0);
        step(1, 16384, 0);
        step(-1, 16384, 0);
        step(3, 16384, 0);
        repeat (10) step(0, 0, 0);

        // Reset mid-stream with nonzero pairs in flight.
        for (int i = 1; i <= 6; i++) step(1000 * i + 7, -13 * i, 0);
        step(4242, 99, 1);
        for (int i = 1; i <= 10; i++) step(-500 * i, 17 * i + 3, 0);

        // Random stream with occasional reset.
        for (int i = 0; i < 300; i++) begin
            ra = 24'($urandom);
            rb = 16'($urandom);
            step(longint'($signed(ra)), longint'($signed(rb)), ($urandom_range(0, 31) == 0));
        end
        repeat (10) step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
